xor_parity_accum: RTL and testbench

// - Streaming, parametrised successor to the 2-input XOR gate.
// - Accepts a frame of WIDTH-bit words over a valid/ready handshake.
// - Accumulates the bitwise XOR of all words in the frame.
// - After the last word, presents the word parity, the 1-bit reduction parity and the beat count.
// - Sits between a producer stream and a link/checker stage that needs per-frame parity.

---
 rtl/xor_parity_accum.sv | 123 ++++++++++++
 tb/tb_xor_parity_accum.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/xor_parity_accum.sv
// Purpose : accumulates the bitwise XOR of a valid/ready framed word stream and reports word parity,
//           reduction parity, beat count and overflow once per frame.
// Latency : out_valid rises 1 cycle after the in_last beat is accepted; one frame per N+1 cycles.
// Backpr. : in_ready drops only while a result is held; the result is held stable until out_ready.
//
// Ports:
//   clk, rst                   single clock, synchronous active-high reset
//   in_valid/in_ready          input beat handshake, in_data word, in_last marks final beat
//   out_valid/out_ready        result handshake
//   out_word                   XOR of all words in the frame
//   out_bit                    reduction parity of out_word
//   out_count                  beats accepted in the frame, saturating at MAX_LEN
//   out_overflow               frame had more than MAX_LEN beats
//   exp_parity, out_err        only with PARITY_CHECK_EN: expected parity sampled with the
//                              in_last beat, and out_bit ^ expected parity
// Optional feature macro: PARITY_CHECK_EN
module xor_parity_accum #(
   parameter int WIDTH   = 8,
   parameter int MAX_LEN = 16,
   parameter int CNT_W   = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
`ifdef PARITY_CHECK_EN
   input  logic             exp_parity,
   output logic             out_err,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_word,
   output logic             out_bit,
   output logic [CNT_W-1:0] out_count,
   output logic             out_overflow
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             ovf;
   logic [WIDTH-1:0] acc_nxt;
   logic             beat_acc;

   // A fresh frame starts from the incoming word rather than from the stale accumulator.
   always_comb begin
      acc_nxt = in_data;
      if (state == ACCUM) begin
         acc_nxt = acc ^ in_data;
      end
   end

   assign beat_acc = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         out_bit   <= 1'b0;
`ifdef PARITY_CHECK_EN
         out_err   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE, ACCUM: begin
               if (beat_acc) begin
                  acc     <= acc_nxt;
                  // Reduction parity is registered alongside acc so it always matches out_word.
                  out_bit <= ^acc_nxt;
                  if (state == IDLE) begin
                     cnt <= CNT_W'(1);
                     ovf <= 1'b0;
                  end else if (cnt < CNT_W'(MAX_LEN)) begin
                     cnt <= cnt + CNT_W'(1);
                  end else begin
                     // Count saturates; overflow stays set until the next frame starts.
                     ovf <= 1'b1;
                  end
                  if (in_last) begin
                     state     <= HOLD;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
`ifdef PARITY_CHECK_EN
                     out_err   <= (^acc_nxt) ^ exp_parity;
`endif
                  end else begin
                     state <= ACCUM;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state     <= IDLE;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign out_word     = acc;
   assign out_count    = cnt;
   assign out_overflow = ovf;

endmodule

// File: tb/tb_xor_parity_accum.sv
// Purpose : self-checking bench for xor_parity_accum, directed corner frames plus random frames.
// Latency : checks out_valid exactly one cycle after the in_last beat.
// Backpr. : holds out_ready low for random stretches with in_valid high to check the stall.
module tb_xor_parity_accum;

   localparam int WIDTH   = 8;
   localparam int MAX_LEN = 16;
   localparam int CNT_W   = 5;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_word;
   logic             out_bit;
   logic [CNT_W-1:0] out_count;
   logic             out_overflow;
`ifdef PARITY_CHECK_EN
   logic             exp_parity;
   logic             out_err;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [WIDTH-1:0] frm[$];

   always #5 clk = ~clk;

   xor_parity_accum #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_last      (in_last),
`ifdef PARITY_CHECK_EN
      .exp_parity   (exp_parity),
      .out_err      (out_err),
`endif
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_word     (out_word),
      .out_bit      (out_bit),
      .out_count    (out_count),
      .out_overflow (out_overflow)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset(input int cycles);
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
`ifdef PARITY_CHECK_EN
      exp_parity = 1'b0;
`endif
      repeat (cycles) step();
      rst = 1'b0;
   endtask

   // Sends the words in frm as one frame and checks the result against a plain arithmetic model.
   // ep_mode: 0/1 force the expected parity on the last beat, anything else picks it at random.
   task automatic run_frame(input string tag, input int stall, input bit gaps, input int ep_mode);
      logic [WIDTH-1:0] x_exp;
      int               n;
      int               cnt_exp;
      bit               ovf_exp;
      bit               bit_exp;
      bit               ep;
      n = frm.size();
      x_exp = '0;
      foreach (frm[i]) x_exp = x_exp ^ frm[i];
      cnt_exp = (n > MAX_LEN) ? MAX_LEN : n;
      ovf_exp = (n > MAX_LEN);
      bit_exp = 1'b0;
      for (int b = 0; b < WIDTH; b++) bit_exp = bit_exp ^ x_exp[b];
      ep = (ep_mode == 0 || ep_mode == 1) ? ep_mode[0] : 1'($urandom);

      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               in_valid = 1'b0;
               in_data  = WIDTH'($urandom);
               in_last  = 1'($urandom);
               step();
            end
         end
         if (i == 0) check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
         check_eq({tag, "_no_early_valid"}, 32'(out_valid), 32'd0);
         in_valid = 1'b1;
         in_data  = frm[i];
         in_last  = (i == n - 1);
`ifdef PARITY_CHECK_EN
         exp_parity = (i == n - 1) ? ep : 1'($urandom);
`endif
         step();
      end

      // Producer keeps pushing junk while the result is held; none of it may be taken.
      in_valid  = 1'b1;
      in_data   = WIDTH'($urandom);
      in_last   = 1'($urandom);
      out_ready = (stall == 0);
      check_eq({tag, "_valid"},    32'(out_valid),    32'd1);
      check_eq({tag, "_word"},     32'(out_word),     32'(x_exp));
      check_eq({tag, "_bit"},      32'(out_bit),      32'(bit_exp));
      check_eq({tag, "_count"},    32'(out_count),    32'(cnt_exp));
      check_eq({tag, "_overflow"}, 32'(out_overflow), 32'(ovf_exp));
      check_eq({tag, "_hold_rdy"}, 32'(in_ready),     32'd0);
`ifdef PARITY_CHECK_EN
      check_eq({tag, "_err"},      32'(out_err),      32'(bit_exp ^ ep));
`endif
      for (int s = 0; s < stall; s++) begin
         in_data = WIDTH'($urandom);
         step();
         check_eq({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
         check_eq({tag, "_stall_word"},  32'({out_word, out_count, out_overflow}),
                  32'({x_exp, CNT_W'(cnt_exp), ovf_exp}));
         check_eq({tag, "_stall_rdy"},   32'(in_ready),  32'd0);
      end
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      check_eq({tag, "_taken"},    32'(out_valid), 32'd0);
      check_eq({tag, "_rdy_back"}, 32'(in_ready),  32'd1);
   endtask

   initial begin
      do_reset(2);
      check_eq("rst_in_ready",  32'(in_ready),     32'd1);
      check_eq("rst_out_valid", 32'(out_valid),    32'd0);
      check_eq("rst_word",      32'(out_word),     32'd0);
      check_eq("rst_bit",       32'(out_bit),      32'd0);
      check_eq("rst_count",     32'(out_count),    32'd0);
      check_eq("rst_overflow",  32'(out_overflow), 32'd0);
`ifdef PARITY_CHECK_EN
      check_eq("rst_err",       32'(out_err),      32'd0);
`endif

      frm = '{8'hA5, 8'h0F, 8'hF0};
      run_frame("three", 0, 0, 1);

      frm = '{8'h01};
      run_frame("single", 0, 0, 0);

      frm = '{8'h3C, 8'h77, 8'h10};
      run_frame("stall5", 5, 0, 2);

      frm = {};
      repeat (20) frm.push_back(8'h01);
      run_frame("ovf20", 0, 0, 2);

      frm = {};
      for (int i = 0; i < MAX_LEN; i++) frm.push_back(WIDTH'($urandom));
      run_frame("exact_max", 1, 0, 2);

      frm = {};
      for (int i = 0; i < MAX_LEN + 1; i++) frm.push_back(WIDTH'($urandom));
      run_frame("max_plus1", 0, 1, 2);

      frm = '{8'h3C, 8'h3C, 8'h3C, 8'h3C};
      run_frame("even_same", 0, 0, 2);

      // Reset in the middle of a frame: nothing may come out, next frame starts clean.
      in_valid = 1'b1; in_data = 8'hAA; in_last = 1'b0; step();
      in_data = 8'h55; step();
      do_reset(1);
      check_eq("midrst_valid", 32'(out_valid), 32'd0);
      check_eq("midrst_rdy",   32'(in_ready),  32'd1);
      check_eq("midrst_count", 32'(out_count), 32'd0);
      repeat (3) step();
      check_eq("midrst_quiet", 32'(out_valid), 32'd0);
      frm = '{8'h12, 8'h34};
      run_frame("after_midrst", 0, 0, 2);

      // Reset while a result is held discards it.
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 8'h81; in_last = 1'b1; step();
      in_valid = 1'b0;
      check_eq("holdrst_pre", 32'(out_valid), 32'd1);
      do_reset(1);
      check_eq("holdrst_valid", 32'(out_valid), 32'd0);
      check_eq("holdrst_word",  32'(out_word),  32'd0);
      frm = '{8'hC3};
      run_frame("after_holdrst", 0, 1, 2);

      for (int f = 0; f < 40; f++) begin
         int n;
         n = $urandom_range(1, 20);
         frm = {};
         for (int i = 0; i < n; i++) frm.push_back(WIDTH'($urandom));
         run_frame("rand", $urandom_range(0, 3), 1'($urandom), 2);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
